frame_serializer: RTL

Downstream stage after the parallel filter stage. It accepts 8-sample signed frames (`final_out`-style arrays, `[0:NUM-1]` of signed `DATA_W`) over a valid/ready handshake and holds them in a two-slot ping-pong buffer. It emits the samples one per handshake, index 0 first. Each sample is rounded, shifted and saturated to `OUT_W` bits, and a saturation event counter is kept.

---
 rtl/frame_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/frame_serializer.sv
// frame_serializer: two-slot ping-pong frame buffer that emits one rounded, shifted and
// saturated sample per handshake, and counts the samples that were clipped.
module frame_serializer #(
  parameter int DATA_W = 16,
  parameter int NUM    = 8,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = 12,
  parameter int IDX_W  = $clog2(NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_frame [0:NUM-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     out_sat,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count
);
  localparam logic signed [DATA_W:0]  HALF = (DATA_W+1)'(2**(SHIFT-1));
  localparam logic signed [DATA_W:0]  QMAX = (DATA_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [DATA_W:0]  QMIN = ~QMAX;
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = ~OMAX;
  localparam logic [IDX_W-1:0]        LAST = IDX_W'(NUM-1);
  logic signed [DATA_W-1:0] slot_q [0:1][0:NUM-1];
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      sat_q, sat_d;
  logic signed [DATA_W:0] r, q;
  logic accept, fire, free, hi, lo;
  always_comb begin
    in_ready  = occ_q != 2'd2;
    out_valid = occ_q != 2'd0;
    accept    = in_valid && in_ready;
    fire      = out_valid && out_ready;
    free      = fire && idx_q == LAST;
    r         = {slot_q[rd_ptr_q][idx_q][DATA_W-1], slot_q[rd_ptr_q][idx_q]} + HALF;
    q         = r >>> SHIFT;
    hi        = q > QMAX;
    lo        = q < QMIN;
    out_data  = hi ? OMAX : lo ? OMIN : q[OUT_W-1:0];
    out_sat   = out_valid && (hi || lo);
    out_last  = out_valid && idx_q == LAST;
    out_index = idx_q;
    sat_count = sat_q;
    // accept and free in the same cycle cancel out
    occ_d     = (accept && !free) ? occ_q + 2'd1 : (free && !accept) ? occ_q - 2'd1 : occ_q;
    wr_ptr_d  = wr_ptr_q ^ accept;
    rd_ptr_d  = rd_ptr_q ^ free;
    idx_d     = free ? '0 : fire ? idx_q + 1'b1 : idx_q;
    sat_d     = sat_clr ? '0 : (fire && out_sat && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= '0;
      sat_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      sat_q    <= sat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < NUM; i++) slot_q[wr_ptr_q][i] <= in_frame[i];
  end
endmodule
